// File: rtl/dilithium_pkg.sv
// Dilithium arithmetic constants and the sequencer state type, shared by the
// pointwise sequencers and their coefficient datapaths.
package dilithium_pkg;

  localparam int          N      = 256;
  localparam int          L      = 5;
  localparam int          COEF_W = 32;
  localparam logic [31:0] Q      = 32'd8380417;
  localparam logic [31:0] QINV   = 32'd58728449;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    logic [2:0] res;
    if (len > 3'(L)) begin
      res = 3'(L);
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/polyvecl_pointwise_seq_if.sv
// Control handshake and coefficient RAM ports of the pointwise sequencer.
interface polyvecl_pointwise_seq_if;
  import dilithium_pkg::*;

  logic              start;
  logic [2:0]        vec_len;
  logic [7:0]        a_addr;
  logic [COEF_W-1:0] a_rdata;
  logic [10:0]       v_addr;
  logic [COEF_W-1:0] v_rdata;
  logic              r_we;
  logic [10:0]       r_addr;
  logic [COEF_W-1:0] r_wdata;
  logic              busy;
  logic              done;

  modport master (
    output start, vec_len, a_rdata, v_rdata,
    input  a_addr, v_addr, r_we, r_addr, r_wdata, busy, done
  );

  modport slave (
    input  start, vec_len, a_rdata, v_rdata,
    output a_addr, v_addr, r_we, r_addr, r_wdata, busy, done
  );

endinterface

// File: rtl/montgomery_mul_pipe.sv
// Two-stage signed coefficient multiply followed by Montgomery reduction,
// result in (-Q, Q); valid travels alongside the data.
module montgomery_mul_pipe
  import dilithium_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_in,
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic              vld_out,
  output logic [COEF_W-1:0] r
);

  logic                  vld1_r;
  logic                  vld2_r;
  logic [2*COEF_W-1:0]   p_r;
  logic [COEF_W-1:0]     r_r;
  logic [COEF_W-1:0]     t_s;
  logic [2*COEF_W-1:0]   tq_s;

  // Reduction factor t = low32(p * QINV), then t*Q sign-extended to 64 bits.
  always_comb begin
    t_s  = p_r[COEF_W-1:0] * QINV;
    tq_s = {{COEF_W{t_s[COEF_W-1]}}, t_s} * {32'd0, Q};
  end

  // Product and reduction stages; p - t*Q has zero low word, keep the high word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_r <= 1'b0;
      vld2_r <= 1'b0;
      p_r    <= 64'd0;
      r_r    <= 32'd0;
    end else begin
      vld1_r <= vld_in;
      vld2_r <= vld1_r;
      p_r    <= {{COEF_W{a[COEF_W-1]}}, a} * {{COEF_W{b[COEF_W-1]}}, b};
      r_r    <= 32'((p_r - tq_s) >> 32);
    end
  end

  assign vld_out = vld2_r;
  assign r       = r_r;

endmodule

// File: rtl/polyvecl_pointwise_seq.sv
// Coefficient-serial sequencer for r[i][j] = mont(a[j] * v[i][j]): one read
// pair per cycle into a shared Montgomery pipe, writes in address order.
module polyvecl_pointwise_seq
  import dilithium_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  polyvecl_pointwise_seq_if.slave bus
);

  seq_state_e                  state_r;
  logic [2:0]                  len_r;
  logic [2:0]                  poly_r;
  logic [7:0]                  coef_r;
  logic                        iss_vld_r;
  logic                        busy_r;
  logic                        done_r;
  logic [RD_LAT:0]             dl_vld_r;
  logic [RD_LAT+1:0][10:0]     dl_addr_r;
  logic                        last_s;

  assign last_s = (poly_r == (len_r - 3'd1)) && (coef_r == 8'hFF);

  // Job control: accept start, walk the coefficient space, drain, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      len_r     <= 3'd0;
      poly_r    <= 3'd0;
      coef_r    <= 8'd0;
      iss_vld_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            len_r  <= clamp_len(bus.vec_len);
            poly_r <= 3'd0;
            coef_r <= 8'd0;
            busy_r <= 1'b1;
            if (clamp_len(bus.vec_len) == 3'd0) begin
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              iss_vld_r <= 1'b0;
            end else begin
              state_r   <= ST_ISSUE;
              iss_vld_r <= 1'b1;
            end
          end else begin
            busy_r    <= 1'b0;
            iss_vld_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (last_s) begin
            state_r   <= ST_DRAIN;
            iss_vld_r <= 1'b0;
          end else begin
            iss_vld_r <= 1'b1;
            coef_r    <= coef_r + 8'd1;
            if (coef_r == 8'hFF) begin
              poly_r <= poly_r + 3'd1;
            end else begin
              poly_r <= poly_r;
            end
          end
        end
        ST_DRAIN: begin
          // The final write is in the output register once earlier stages are empty.
          if (dl_vld_r == {(RD_LAT+1){1'b0}}) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          iss_vld_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Delay line aligning issued addresses with the pipe output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_r  <= {(RD_LAT+1){1'b0}};
      dl_addr_r <= {((RD_LAT+2)*11){1'b0}};
    end else begin
      dl_vld_r  <= {dl_vld_r[RD_LAT-1:0], iss_vld_r};
      dl_addr_r <= {dl_addr_r[RD_LAT:0], poly_r, coef_r};
    end
  end

  montgomery_mul_pipe u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (dl_vld_r[RD_LAT-1]),
    .a       (bus.a_rdata),
    .b       (bus.v_rdata),
    .vld_out (bus.r_we),
    .r       (bus.r_wdata)
  );

  assign bus.a_addr = coef_r;
  assign bus.v_addr = {poly_r, coef_r};
  assign bus.r_addr = dl_addr_r[RD_LAT+1];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule
